// File: rtl/mem_request_unit_pkg.sv
// mem_request_unit_pkg: shared encodings for the memory-request stage
// (writeback select, access size, FSM state).
package mem_request_unit_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        WB_ALU     = 2'b00,
        WB_DMEM    = 2'b01,
        WB_PC_ADD4 = 2'b10
    } wbsel_e;

    // Access size lives in funct3[1:0]; funct3[2] only marks unsigned loads.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_request_unit_store_align.sv
// mem_request_unit_store_align: places store data on its byte lanes and
// flags halfword/word accesses that straddle their natural alignment.
module mem_request_unit_store_align
    import mem_request_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] rs2,
    output logic [31:0] wdata,
    output logic [3:0]  wbe,
    output logic        misaligned
);
    always_comb begin
        wdata      = size == SZ_BYTE ? {4{rs2[7:0]}} : size == SZ_HALF ? {2{rs2[15:0]}} : rs2;
        wbe        = size == SZ_BYTE ? 4'b0001 << lane : size == SZ_HALF ? 4'b0011 << lane : 4'b1111;
        misaligned = size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? lane[0] : lane != 2'b00;
    end

endmodule

// File: rtl/mem_request_unit.sv
// mem_request_unit: memory-stage front-end; issues loads/stores on the data bus,
// stalls Execute while a transaction is outstanding and registers writeback fields.
module mem_request_unit
    import mem_request_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rs2,
    input  logic [31:0] ex_inst,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [2:0]  ex_ldsel,
    input  logic [1:0]  ex_wbsel,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_wbe,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_dmem_out,
    output logic [31:0] wb_inst,
    output logic [2:0]  wb_ldsel,
    output logic [1:0]  wb_wbsel,
    output logic        misalign,
    output logic        bus_err
);
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_pc;
    logic [31:0]      pend_alu_out;
    logic [31:0]      pend_inst;
    logic [2:0]       pend_ldsel;
    logic [1:0]       pend_wbsel;
    logic [31:0]      al_wdata;
    logic [3:0]       al_wbe;
    logic             al_misaligned;
    logic             accept;
    logic             mem_op;
    logic             direct;
    logic             timed_out;
    logic             done_store;
    logic             done_load;
    logic             abandon;
    logic             retire_mem;

    mem_request_unit_store_align u_align (
        .size       (ex_inst[13:12]),
        .lane       (ex_alu_out[1:0]),
        .rs2        (ex_rs2),
        .wdata      (al_wdata),
        .wbe        (al_wbe),
        .misaligned (al_misaligned)
    );

    assign ex_ready      = state == IDLE;
    assign bus_req_valid = state == REQ;
    assign accept        = ex_valid && ex_ready;
    assign mem_op        = ex_mem_rd || ex_mem_wr;
    // Non-memory ops and dropped misaligned accesses retire straight from IDLE.
    assign direct        = accept && (!mem_op || al_misaligned);
    assign timed_out     = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign done_store    = state == REQ && bus_req_ready && bus_req_we;
    assign done_load     = state == WAIT_RSP && bus_rsp_valid;
    assign abandon       = timed_out && ((state == REQ && !bus_req_ready) || (state == WAIT_RSP && !bus_rsp_valid));
    assign retire_mem    = done_store || done_load || abandon;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            pend_pc       <= '0;
            pend_alu_out  <= '0;
            pend_inst     <= '0;
            pend_ldsel    <= '0;
            pend_wbsel    <= '0;
            bus_req_we    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            bus_req_wbe   <= '0;
        end else begin
            if (state != IDLE)
                cnt <= cnt + 1'b1;
            if (accept && mem_op && !al_misaligned) begin
                state         <= REQ;
                cnt           <= '0;
                pend_pc       <= ex_pc;
                pend_alu_out  <= ex_alu_out;
                pend_inst     <= ex_inst;
                pend_ldsel    <= ex_ldsel;
                pend_wbsel    <= ex_wbsel;
                bus_req_we    <= ex_mem_wr;
                bus_req_addr  <= {ex_alu_out[31:2], 2'b00};
                bus_req_wdata <= al_wdata;
                bus_req_wbe   <= ex_mem_wr ? al_wbe : 4'b0000;
            end else if (state == REQ && bus_req_ready && !bus_req_we) begin
                state <= WAIT_RSP;
                cnt   <= '0;
            end else if (retire_mem) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
            wb_pc       <= '0;
            wb_alu_out  <= '0;
            wb_dmem_out <= '0;
            wb_inst     <= '0;
            wb_ldsel    <= '0;
            wb_wbsel    <= '0;
        end else begin
            wb_valid <= direct || retire_mem;
            misalign <= direct && mem_op;
            bus_err  <= abandon;
            if (direct) begin
                wb_pc       <= ex_pc;
                wb_alu_out  <= ex_alu_out;
                wb_dmem_out <= '0;
                wb_inst     <= ex_inst;
                wb_ldsel    <= ex_ldsel;
                wb_wbsel    <= ex_wbsel;
            end else if (retire_mem) begin
                wb_pc       <= pend_pc;
                wb_alu_out  <= pend_alu_out;
                wb_dmem_out <= done_load ? bus_rsp_rdata : '0;
                wb_inst     <= pend_inst;
                wb_ldsel    <= pend_ldsel;
                wb_wbsel    <= pend_wbsel;
            end
        end
    end

endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: directed stimulus against a transaction-level model of
// expected bus requests and retirements, plus hand-computed spot checks.
module tb_mem_request_unit;
    import mem_request_unit_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_pc = '0, ex_alu_out = '0, ex_rs2 = '0, ex_inst = '0;
    logic        ex_mem_rd = 1'b0, ex_mem_wr = 1'b0;
    logic [2:0]  ex_ldsel = '0;
    logic [1:0]  ex_wbsel = '0;
    logic        bus_req_valid, bus_req_we;
    logic        bus_req_ready = 1'b1;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_wbe;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_rdata = '0;
    logic        wb_valid, misalign, bus_err;
    logic [31:0] wb_pc, wb_alu_out, wb_dmem_out, wb_inst;
    logic [2:0]  wb_ldsel;
    logic [1:0]  wb_wbsel;

    always #5 clk = ~clk;

    mem_request_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_alu_out(ex_alu_out),
        .ex_rs2(ex_rs2), .ex_inst(ex_inst), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_ldsel(ex_ldsel), .ex_wbsel(ex_wbsel),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
        .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wbe(bus_req_wbe),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_alu_out(wb_alu_out), .wb_dmem_out(wb_dmem_out),
        .wb_inst(wb_inst), .wb_ldsel(wb_ldsel), .wb_wbsel(wb_wbsel),
        .misalign(misalign), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] pc, alu, dmem, inst;
        logic [2:0]  ldsel;
        logic [1:0]  wbsel;
        logic        mis, err;
    } ret_t;
    typedef struct {
        logic        we;
        logic [31:0] addr, wdata;
        logic [3:0]  wbe;
    } req_t;

    ret_t        ret_q[$];
    req_t        req_q[$];
    ret_t        ce;
    req_t        cr;
    int          vectors = 0, miscompares = 0;
    int          rsp_delay = 0;
    logic [31:0] rsp_data = '0;
    int          busy = 0, last_busy = 0, wb_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus slave: answers a load a fixed number of cycles after the request is accepted.
    always begin
        @(negedge clk);
        if (!rst && bus_req_valid && bus_req_ready && !bus_req_we && rsp_delay > 0) begin
            repeat (rsp_delay) @(posedge clk);
            #1 bus_rsp_valid = 1'b1;
            bus_rsp_rdata = rsp_data;
            @(posedge clk);
            #1 bus_rsp_valid = 1'b0;
        end
    end

    // Compare process: every retirement and every accepted request against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (ex_ready) begin
                if (busy != 0) last_busy = busy;
                busy = 0;
            end else busy++;
            if (wb_valid) begin
                wb_count++;
                if (ret_q.size() == 0) check("wb_unexpected_qsize", ret_q.size(), 1);
                else begin
                    ce = ret_q.pop_front();
                    check("wb_pc", wb_pc, ce.pc);
                    check("wb_alu_out", wb_alu_out, ce.alu);
                    check("wb_dmem_out", wb_dmem_out, ce.dmem);
                    check("wb_inst", wb_inst, ce.inst);
                    check("wb_ldsel", wb_ldsel, ce.ldsel);
                    check("wb_wbsel", wb_wbsel, ce.wbsel);
                    check("misalign", misalign, ce.mis);
                    check("bus_err", bus_err, ce.err);
                end
            end else if (misalign || bus_err) check("pulse_without_wb", wb_valid, 1);
            if (bus_req_valid && bus_req_ready) begin
                if (req_q.size() == 0) check("req_unexpected_qsize", req_q.size(), 1);
                else begin
                    cr = req_q.pop_front();
                    check("req_we", bus_req_we, cr.we);
                    check("req_addr", bus_req_addr, cr.addr);
                    check("req_wbe", bus_req_wbe, cr.wbe);
                    if (cr.we) check("req_wdata", bus_req_wdata, cr.wdata);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!ex_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ex_ready) check("ready_timeout", ex_ready, 1);
    endtask

    // Presents one op, records what the bus and writeback must eventually show, and
    // returns 1ns after the handshake edge.
    task automatic issue(input logic [31:0] pc, alu, rs2, inst, input logic rd, wr,
                         input logic [2:0] ldsel, input logic [1:0] wbsel);
        ret_t e;
        req_t r;
        logic [1:0] sz, lane;
        logic mis, mem;
        wait_idle();
        sz   = inst[13:12];
        lane = alu[1:0];
        mem  = rd || wr;
        mis  = mem && (sz == 2'd0 ? 1'b0 : sz == 2'd1 ? lane[0] : lane != 2'd0);
        e.pc = pc; e.alu = alu; e.inst = inst; e.ldsel = ldsel; e.wbsel = wbsel; e.mis = mis;
        e.err  = rd && !mis && rsp_delay <= 0;
        e.dmem = (rd && !mis && rsp_delay > 0) ? rsp_data : 32'h0;
        if (mem && !mis) begin
            r.we    = wr;
            r.addr  = alu & ~32'd3;
            r.wbe   = !wr ? 4'h0 : sz == 2'd0 ? 4'(1 << lane) : sz == 2'd1 ? 4'(3 << lane) : 4'hf;
            r.wdata = sz == 2'd0 ? rs2[7:0] * 32'h01010101 : sz == 2'd1 ? rs2[15:0] * 32'h00010001 : rs2;
            req_q.push_back(r);
        end
        ret_q.push_back(e);
        ex_pc = pc; ex_alu_out = alu; ex_rs2 = rs2; ex_inst = inst;
        ex_mem_rd = rd; ex_mem_wr = wr; ex_ldsel = ldsel; ex_wbsel = wbsel;
        ex_valid = 1'b1;
        @(posedge clk);
        #1 ex_valid = 1'b0;
    endtask

    initial begin
        int snap;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_ready", ex_ready, 1);
        check("rst_req_valid", bus_req_valid, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_pc", wb_pc, 0);
        check("rst_wb_dmem", wb_dmem_out, 0);
        check("rst_pulses", {misalign, bus_err}, 0);
        rst = 1'b0;
        cycles(1);

        // SW, ready already high
        issue(32'h100, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0000_2023, 0, 1, 3'd0, WB_ALU);
        check("sw_req_valid", bus_req_valid, 1);
        check("sw_addr", bus_req_addr, 32'h1000_0004);
        check("sw_wbe", bus_req_wbe, 4'b1111);
        check("sw_wdata", bus_req_wdata, 32'hDEAD_BEEF);
        cycles(1);
        check("sw_wb_valid", wb_valid, 1);

        // SB at lane 3 with the bus stalling two cycles
        bus_req_ready = 1'b0;
        issue(32'h104, 32'h0000_0013, 32'h0000_00AB, 32'h0000_0023, 0, 1, 3'd0, WB_ALU);
        cycles(2);
        check("sb_held_valid", bus_req_valid, 1);
        check("sb_addr", bus_req_addr, 32'h0000_0010);
        check("sb_wbe", bus_req_wbe, 4'b1000);
        check("sb_wdata", bus_req_wdata, 32'hABAB_ABAB);
        bus_req_ready = 1'b1;
        cycles(1);
        check("sb_wb_valid", wb_valid, 1);

        // LW with response three cycles after request acceptance
        rsp_delay = 3; rsp_data = 32'h1234_5678;
        issue(32'h108, 32'h20, 32'h0, 32'h0000_2003, 1, 0, 3'd2, WB_DMEM);
        wait_idle();
        check("lw_dmem", wb_dmem_out, 32'h1234_5678);
        check("lw_alu", wb_alu_out, 32'h20);
        @(negedge clk);
        #1 check("lw_busy_cycles", last_busy, 4);

        // LHU at lane 2 and SH at lane 2 (aligned halves)
        rsp_delay = 1; rsp_data = 32'hCAFE_F00D;
        issue(32'h10C, 32'h22, 32'h0, 32'h0000_5003, 1, 0, 3'd4, WB_DMEM);
        issue(32'h110, 32'h102, 32'h1234_BEEF, 32'h0000_1023, 0, 1, 3'd0, WB_ALU);
        wait_idle();

        // SH misaligned: dropped, no request, pulses together
        issue(32'h114, 32'h01, 32'h5555, 32'h0000_1023, 0, 1, 3'd0, WB_ALU);
        check("sh_mis_no_req", bus_req_valid, 0);
        check("sh_mis_pulse", {misalign, wb_valid}, 2'b11);
        check("sh_mis_dmem", wb_dmem_out, 0);
        issue(32'h118, 32'h22, 32'h0, 32'h0000_2003, 1, 0, 3'd2, WB_DMEM);

        // LW with no response times out
        rsp_delay = -1;
        issue(32'h200, 32'h30, 32'h0, 32'h0000_2003, 1, 0, 3'd2, WB_DMEM);
        wait_idle();
        check("to_bus_err", bus_err, 1);
        check("to_dmem", wb_dmem_out, 0);
        @(negedge clk);
        #1 check("to_busy_cycles", last_busy, TO + 1);
        issue(32'h204, 32'h77, 32'h0, 32'h0000_0033, 0, 0, 3'd0, WB_PC_ADD4);
        check("after_to_accept", wb_pc, 32'h204);

        // Reset while waiting for a response; the late response must be ignored
        rsp_delay = 4; rsp_data = 32'hBAD0_BAD0;
        issue(32'h300, 32'h40, 32'h0, 32'h0000_2003, 1, 0, 3'd2, WB_DMEM);
        cycles(2);
        check("wait_busy", ex_ready, 0);
        rst = 1'b1;
        #1;
        check("arst_req_valid", bus_req_valid, 0);
        check("arst_wb_valid", wb_valid, 0);
        check("arst_ex_ready", ex_ready, 1);
        check("arst_wb_pc", wb_pc, 0);
        ret_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        snap = wb_count;
        cycles(6);
        check("late_rsp_ignored", wb_count - snap, 0);

        // Three ADDs back to back
        snap = wb_count;
        issue(32'h400, 32'h1, 32'h0, 32'h00B5_0533, 0, 0, 3'd0, WB_ALU);
        issue(32'h404, 32'h2, 32'h0, 32'h00B5_0533, 0, 0, 3'd0, WB_ALU);
        issue(32'h408, 32'h3, 32'h0, 32'h00B5_0533, 0, 0, 3'd0, WB_ALU);
        check("b2b_last_valid", wb_valid, 1);
        @(negedge clk);
        #1 check("b2b_wb_count", wb_count - snap, 3);

        cycles(3);
        check("ret_q_drained", ret_q.size(), 0);
        check("req_q_drained", req_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
